fft_sample_mem_slave: RTL and testbench

FFT_SAMPLE_MEM_SLAVE -- requirements
Module: fft_sample_mem_slave

---
 rtl/fft_sample_mem_slave_if.sv | 24 ++
 rtl/fft_sample_mem_slave.sv | 114 +++++++++++
 tb/tb_fft_sample_mem_slave.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_sample_mem_slave_if.sv
// Avalon-MM slave bus between the FFT core master and the sample buffer.
// Signal names follow the Avalon avs_* naming so the core-side wiring reads naturally.
interface fft_sample_mem_slave_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 9
) ();
    logic [AWIDTH-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DWIDTH-1:0] avs_writedata;
    logic [DWIDTH-1:0] avs_readdata;
    logic              avs_waitrequest;
    logic              avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest, avs_readdatavalid
    );
endinterface

// File: rtl/fft_sample_mem_slave.sv
// Audio sample frame buffer: fills DEPTH words from a sample stream, then lets the FFT
// core read and overwrite them in place over an Avalon-MM slave port with 2-cycle reads.
module fft_sample_mem_slave #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 9,
    parameter int DEPTH  = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fft_sample_mem_slave_if.slave bus,
    input  logic                  smp_valid_i,
    input  logic [15:0]           smp_data_i,
    output logic                  smp_ready_o,
    output logic                  frame_rdy_o
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, READY} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     fillCnt_q, fillCnt_d;
    logic              smpReady_q, frameRdy_q;
    logic              rdValid1_q, rdValid2_q;
    logic [DWIDTH-1:0] rdData1_q, rdData2_q, rdData_d;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] csrVal;
    logic [IW-1:0]     addrIdx;
    logic              inBuf, isCsr, smpAccept, waitReq, wrAccept, rdAccept, csrStart;

    assign addrIdx   = bus.avs_address[IW-1:0];
    assign inBuf     = bus.avs_address < AWIDTH'(DEPTH);
    assign isCsr     = bus.avs_address == AWIDTH'(DEPTH);
    assign smpAccept = smp_valid_i & smpReady_q & ~rst_i;

    // The stream owns the single RAM port; only buffer-region bus accesses are held off.
    assign waitReq  = rst_i | ((bus.avs_read | bus.avs_write) & inBuf & smpAccept);
    assign wrAccept = bus.avs_write & ~waitReq;
    assign rdAccept = bus.avs_read & ~bus.avs_write & ~waitReq;
    assign csrStart = wrAccept & isCsr & bus.avs_writedata[0];

    assign bus.avs_waitrequest   = waitReq;
    assign bus.avs_readdata      = rdData2_q;
    assign bus.avs_readdatavalid = rdValid2_q;
    assign smp_ready_o           = smpReady_q;
    assign frame_rdy_o           = frameRdy_q;

    always_comb begin
        csrVal    = '0;
        csrVal[1] = (state_q == FILL);
        csrVal[0] = frameRdy_q;
        rdData_d  = '0;
        if (inBuf) begin
            rdData_d = mem[addrIdx];
        end else if (isCsr) begin
            rdData_d = csrVal;
        end
    end

    always_comb begin
        state_d   = state_q;
        fillCnt_d = fillCnt_q;
        case (state_q)
            IDLE, READY: begin
                if (csrStart) begin
                    state_d   = FILL;
                    fillCnt_d = '0;
                end
            end
            FILL: begin
                if (csrStart) begin
                    fillCnt_d = '0;
                end else if (smpAccept) begin
                    if (fillCnt_q == IW'(DEPTH - 1)) begin
                        state_d = READY;
                    end else begin
                        fillCnt_d = fillCnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            fillCnt_q  <= '0;
            smpReady_q <= 1'b0;
            frameRdy_q <= 1'b0;
            rdValid1_q <= 1'b0;
            rdValid2_q <= 1'b0;
            rdData1_q  <= '0;
            rdData2_q  <= '0;
        end else begin
            state_q    <= state_d;
            fillCnt_q  <= fillCnt_d;
            smpReady_q <= (state_d == FILL);
            frameRdy_q <= (state_d == READY);
            rdValid1_q <= rdAccept;
            rdData1_q  <= rdData_d;
            rdValid2_q <= rdValid1_q;
            rdData2_q  <= rdData1_q;
        end
    end

    // Buffer contents deliberately survive reset so a captured frame is not lost.
    always_ff @(posedge clk_i) begin
        if (smpAccept) begin
            mem[fillCnt_q] <= DWIDTH'({smp_data_i, 16'h0000});
        end else if (wrAccept && inBuf) begin
            mem[addrIdx] <= bus.avs_writedata;
        end
    end
endmodule

// File: tb/tb_fft_sample_mem_slave.sv
// Randomised plus scenario-driven bench for fft_sample_mem_slave, checked against a
// frame-buffer reference model with a queue of expected read responses.
module tb_fft_sample_mem_slave;
    localparam int DEPTH = 256;

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          known;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        smpValid = 1'b0;
    logic [15:0] smpData = '0;
    logic        smpReady, frameRdy;

    fft_sample_mem_slave_if #(.DWIDTH(32), .AWIDTH(9)) bus ();

    fft_sample_mem_slave #(.DWIDTH(32), .AWIDTH(9), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .smp_valid_i (smpValid),
        .smp_data_i  (smpData),
        .smp_ready_o (smpReady),
        .frame_rdy_o (frameRdy)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    exp_t        expQ [$];
    logic [31:0] mMem [DEPTH];
    bit          mKnown [DEPTH];
    bit          mFilling = 1'b0;
    bit          mFull = 1'b0;
    int          mCount = 0;
    bit          mRstSeen = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Reference model: tracks frame-buffer behaviour at each clock edge and queues read responses.
    always @(posedge clk) begin
        bit   smpAcc, inB, isC, stall, start;
        int   a;
        exp_t e;
        cyc++;
        if (rst) begin
            expQ.delete();
            mFilling = 1'b0;
            mFull    = 1'b0;
            mCount   = 0;
            mRstSeen = 1'b1;
        end else begin
            mRstSeen = 1'b0;
            a      = int'(bus.avs_address);
            smpAcc = smpValid && mFilling;
            inB    = a < DEPTH;
            isC    = a == DEPTH;
            stall  = (bus.avs_read || bus.avs_write) && inB && smpAcc;
            start  = 1'b0;
            if (!stall) begin
                if (bus.avs_write) begin
                    if (inB) begin
                        mMem[a]   = bus.avs_writedata;
                        mKnown[a] = 1'b1;
                    end else if (isC && bus.avs_writedata[0]) begin
                        start = 1'b1;
                    end
                end else if (bus.avs_read) begin
                    e.due   = cyc + 1;
                    e.known = 1'b1;
                    if (inB) begin
                        e.data  = mMem[a];
                        e.known = mKnown[a];
                    end else if (isC) begin
                        e.data = {30'b0, mFilling, mFull};
                    end else begin
                        e.data = 32'h0;
                    end
                    expQ.push_back(e);
                end
            end
            if (smpAcc) begin
                mMem[mCount]   = {smpData, 16'h0000};
                mKnown[mCount] = 1'b1;
            end
            if (start) begin
                mFilling = 1'b1;
                mFull    = 1'b0;
                mCount   = 0;
            end else if (smpAcc) begin
                if (mCount == DEPTH - 1) begin
                    mFilling = 1'b0;
                    mFull    = 1'b1;
                end else begin
                    mCount++;
                end
            end
        end
    end

    // Monitor: compares handshake outputs every cycle and pops the scoreboard on each readdatavalid.
    always @(negedge clk) begin
        exp_t e;
        bit   expWait;
        if (cyc > 0) begin
            expWait = rst || ((bus.avs_read || bus.avs_write) && (int'(bus.avs_address) < DEPTH)
                              && smpValid && mFilling);
            checkOutput("waitrequest", 32'(bus.avs_waitrequest), 32'(expWait));
            checkOutput("smp_ready", 32'(smpReady), 32'(mFilling));
            checkOutput("frame_rdy", 32'(frameRdy), 32'(mFull));
            if (mRstSeen) begin
                checkOutput("rdata_after_reset", bus.avs_readdata, 32'h0);
            end
            if (bus.avs_readdatavalid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_rvalid", 32'(bus.avs_readdatavalid), 32'h0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rvalid_cycle", 32'(cyc), 32'(e.due));
                    if (e.known) begin
                        checkOutput("rdata", bus.avs_readdata, e.data);
                    end
                end
            end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
                e = expQ.pop_front();
                checkOutput("missing_rvalid", 32'(bus.avs_readdatavalid), 32'h1);
            end
        end
    end

    task automatic applyStimulus(input bit rd, input bit wr, input logic [8:0] addr,
                                 input logic [31:0] wd, input bit sv, input logic [15:0] sd);
        bus.avs_read      = rd;
        bus.avs_write     = wr;
        bus.avs_address   = addr;
        bus.avs_writedata = wd;
        smpValid          = sv;
        smpData           = sd;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 16'h0);
    endtask

    initial begin
        int          r, p;
        bit          rd, wr, sv;
        logic [8:0]  addr;
        logic [31:0] wd;

        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_address   = '0;
        bus.avs_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(2);

        // Fill a full frame with 1..256, then read back a word.
        applyStimulus(1'b0, 1'b1, 9'd256, 32'h1, 1'b0, 16'h0);
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b0, 1'b0, 9'd0, 32'h0, 1'b1, 16'(i));
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 9'd5, 32'h0, 1'b0, 16'h0);
        idleCycles(3);

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 9'(i), 32'h0, 1'b0, 16'h0);
        idleCycles(4);

        // Contention between the stream and the bus while filling.
        applyStimulus(1'b0, 1'b1, 9'd256, 32'h1, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 9'd10, 32'h0, 1'b1, 16'h7000 + 16'(i));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 9'd256, 32'h0, 1'b1, 16'h7100 + 16'(i));
        applyStimulus(1'b1, 1'b0, 9'd10, 32'h0, 1'b0, 16'h0);
        idleCycles(3);

        applyStimulus(1'b0, 1'b1, 9'd200, 32'h12345678, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 9'd200, 32'h0, 1'b0, 16'h0);
        idleCycles(3);

        // Restart mid-fill after 100 samples.
        applyStimulus(1'b0, 1'b1, 9'd256, 32'h1, 1'b0, 16'h0);
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 9'd0, 32'h0, 1'b1, 16'h1000 + 16'(i));
        applyStimulus(1'b0, 1'b1, 9'd256, 32'h1, 1'b0, 16'h0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 9'd0, 32'h0, 1'b1, 16'h2000 + 16'(i));
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 9'd0, 32'h0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 9'd256, 32'h0, 1'b0, 16'h0);
        idleCycles(3);

        // Reset one cycle after a read is accepted.
        applyStimulus(1'b1, 1'b0, 9'd3, 32'h0, 1'b0, 16'h0);
        rst = 1'b1;
        idleCycles(2);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 9'd256, 32'h0, 1'b0, 16'h0);
        idleCycles(3);

        for (int i = 0; i < 3000; i++) begin
            if (i % 800 == 0) begin
                applyStimulus(1'b0, 1'b1, 9'd256, 32'h1, 1'b0, 16'h0);
            end
            r    = int'($urandom_range(0, 99));
            p    = int'($urandom_range(0, 99));
            sv   = ($urandom_range(0, 3) != 0);
            rd   = (r < 30) || (r >= 90);
            wr   = (r >= 30) && (r < 55) || (r >= 90);
            if (p < 85)      addr = 9'($urandom_range(0, DEPTH - 1));
            else if (p < 92) addr = 9'd256;
            else             addr = 9'($urandom_range(257, 511));
            wd = $urandom;
            if (addr == 9'd256) wd[0] = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 699) == 0);
            applyStimulus(rd, wr, addr, wd, sv, 16'($urandom));
            rst = 1'b0;
        end

        idleCycles(5);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
